// File: rtl/ex_div_seq_pkg.sv
// Shared encodings and constants for the EX-stage division sequencer.
package ex_div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int unsigned DoubleRegBus = 64;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

endpackage

// File: rtl/ex_div_seq_div_step.sv
// One restoring-division iteration over the {partial remainder, dividend shift} register.
module ex_div_seq_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W:0]  work,
  input  logic [DATA_W-1:0]  divisor,
  output logic [2*DATA_W:0]  work_next
);

  logic [DATA_W:0]   part_rem;
  logic              fits;
  logic [DATA_W-1:0] diff;

  // The difference always fits in DATA_W bits when the divisor fits.
  assign part_rem = work[2*DATA_W:DATA_W];
  assign fits     = part_rem >= {1'b0, divisor};
  assign diff     = part_rem[DATA_W-1:0] - divisor;

  always_comb begin
    if (fits) begin
      work_next = {diff, work[DATA_W-1:0], 1'b1};
    end else begin
      work_next = {work[2*DATA_W-1:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle DIV/DIVU sequencer for EX; result is {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_i (magnitude + sign fix-up logic).
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d, step_work;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   a_mag, b_mag, quo_fix, rem_fix;

  ex_div_seq_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .work      (work_q),
    .divisor   (divisor_q),
    .work_next (step_work)
  );

`ifdef DIV_SIGNED_EN
  logic quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic a_neg, b_neg;

  assign a_neg   = signed_i & dividend_i[DATA_W-1];
  assign b_neg   = signed_i & divisor_i[DATA_W-1];
  assign a_mag   = a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign b_mag   = b_neg ? (~divisor_i + 1'b1) : divisor_i;
  assign quo_fix = quo_neg_q ? (~step_work[DATA_W-1:0] + 1'b1) : step_work[DATA_W-1:0];
  assign rem_fix = rem_neg_q ? (~step_work[2*DATA_W:DATA_W+1] + 1'b1)
                             : step_work[2*DATA_W:DATA_W+1];
`else
  logic sign_unused;

  assign sign_unused = signed_i;
  assign a_mag       = dividend_i;
  assign b_mag       = divisor_i;
  assign quo_fix     = step_work[DATA_W-1:0];
  assign rem_fix     = step_work[2*DATA_W:DATA_W+1];
`endif

  assign stallreq_o = start_i & ~ready_q & ~annul_i;
  assign result_o   = result_q;
  assign ready_o    = ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    ready_d   = ready_q;
`ifdef DIV_SIGNED_EN
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
`endif
    if (state_q != DivFree && annul_i) begin
      state_d  = DivFree;
      result_d = '0;
      ready_d  = DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            if (divisor_i == '0) begin
              state_d = DivByZero;
            end else begin
              state_d   = DivOn;
              cnt_d     = '0;
              work_d    = {{DATA_W{1'b0}}, a_mag, 1'b0};
              divisor_d = b_mag;
`ifdef DIV_SIGNED_EN
              quo_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
`endif
            end
          end
        end
        DivByZero: begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
        DivOn: begin
          work_d = step_work;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d  = DivEnd;
            result_d = {rem_fix, quo_fix};
            ready_d  = DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state_d  = DivFree;
            result_d = '0;
            ready_d  = DivResultNotReady;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
`ifdef DIV_SIGNED_EN
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: latency, results, divide-by-zero, annul, hold and reset.
module tb_ex_div_seq;
  import ex_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, annul_i, signed_i;
  logic [31:0] dividend_i, divisor_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_div_seq #(
    .DATA_W (32),
    .CNT_W  (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept in the current cycle, scramble operands afterwards, wait for ready_o.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat = 0;
    int stall_bad = 0;
    start_i = 1'b1; annul_i = 1'b0; signed_i = sgn; dividend_i = a; divisor_i = b;
    #1;
    if (stallreq_o !== 1'b1) stall_bad++;
    do begin
      tick();
      lat++;
      dividend_i = ~a;
      divisor_i  = 32'h0;
      if (ready_o !== 1'b1 && stallreq_o !== 1'b1) stall_bad++;
    end while (ready_o !== 1'b1 && lat < 100);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp);
    check({tag, "_stall_while_busy"}, 64'(stall_bad), 64'd0);
    check({tag, "_stall_at_ready"}, 64'(stallreq_o), 64'd0);
  endtask

  task automatic end_div(input string tag);
    start_i = 1'b0;
    tick();
    check({tag, "_ready_clr"}, 64'(ready_o), 64'd0);
    check({tag, "_result_clr"}, result_o, 64'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ready_o !== 1'b0) seen++;
    end
    check({tag, "_no_ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, {ZeroWord, ZeroWord});
    check("reset_stall", 64'(stallreq_o), 64'd0);
    check("result_width", 64'($bits(result_o)), 64'(DoubleRegBus));
    check("reset_state", 64'(dut.state_q), 64'(DivFree));

    // 100 / 7 = 14 r 2, then hold start for 3 more cycles.
    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    held = result_o;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, held);
    end
    end_div("u100_7");
    // Restart straight after the mandatory idle cycle.
    run_div("uffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);
    end_div("uffff_10");

    run_div("u_top_rem", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33);
    end_div("u_top_rem");
    run_div("u_by_one", 1'b0, 32'h1234_5678, 32'h1, {32'h0, 32'h1234_5678}, 33);
    end_div("u_by_one");
    run_div("u_small", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33);
    end_div("u_small");

    // Divide by zero.
    run_div("div0", 1'b0, 32'd1234, 32'd0, 64'd0, 2);
    end_div("div0");
    check("div0_state_free", 64'(dut.state_q), 64'(DivFree));

    // Annul at T+10 of a division.
    start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (10) tick();
    annul_i = 1'b1;
    #1;
    check("annul_stall", 64'(stallreq_o), 64'd0);
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    check("annul_state_free", 64'(dut.state_q), 64'(DivFree));
    check("annul_ready", 64'(ready_o), 64'd0);
    expect_quiet("annul", 40);
    run_div("post_annul", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);
    end_div("post_annul");

    // Annul in IDLE suppresses the request.
    start_i = 1'b1; annul_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
    tick();
    check("idle_annul_state", 64'(dut.state_q), 64'(DivFree));
    start_i = 1'b0; annul_i = 1'b0;
    expect_quiet("idle_annul", 5);

    // Reset in the middle of ON.
    start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_ready", 64'(ready_o), 64'd0);
    check("mid_rst_result", result_o, 64'd0);
    check("mid_rst_state", 64'(dut.state_q), 64'(DivFree));
    rst = 1'b0; start_i = 1'b0;
    expect_quiet("mid_rst", 40);

`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    end_div("s_m7_2");
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    end_div("s_ovf");
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33);
    end_div("s_7_m2");
    run_div("s_as_u", 1'b0, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC}, 33);
    end_div("s_as_u");
`else
    // signed_i is ignored: -7 / 2 is computed as DIVU.
    run_div("sign_ignored", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC}, 33);
    end_div("sign_ignored");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Multi-cycle sequencer for 32-bit integer division (DIV/DIVU), used by the EX stage.
- Accepts an operand pair from EX and runs one restoring-division step per cycle.
- Holds EX (via stallreq_o) until it returns {remainder, quotient} for the HI/LO write.
- Handles divide-by-zero, annul on branch/exception flush, and back-to-back requests.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  division request; EX holds it high until ready_o is seen
- annul_i  in  1  flush; aborts an in-flight or pending division
- signed_i  in  1  1 = DIV (signed), 0 = DIVU
- dividend_i  in  DATA_W  numerator; sampled only on the accept cycle
- divisor_i  in  DATA_W  denominator; sampled only on the accept cycle
- result_o  out  2*DATA_W  {remainder, quotient}; remainder goes to HI, quotient to LO
- ready_o  out  1  result_o valid
- stallreq_o  out  1  stall request to pipeline control

Behaviour:
- Reset: state IDLE; counter 0; result_o 0; ready_o 0; stallreq_o 0. Reset mid-operation discards all work and takes priority over every other input.
- Registers: state, counter, 65-bit working register {partial remainder, dividend shift}, latched divisor, latched sign flags.
- Every output is registered except stallreq_o.
- stallreq_o = start_i & ~ready_o & ~annul_i (combinational).
- IDLE:
  - start_i=1, annul_i=0, divisor_i≠0: latch operands (magnitudes if signed), counter←0, go to ON.
  - start_i=1, annul_i=0, divisor_i=0: go to BYZERO.
  - Otherwise stay in IDLE.
- ON (one iteration per cycle):
  - diff = partial remainder minus divisor, computed at DATA_W+1 bits.
  - If diff ≥ 0: partial remainder ← diff and shift in 1; otherwise shift in 0.
  - counter increments each cycle.
  - After iteration DATA_W-1: apply sign fix-up, load result_o, set ready_o←1, go to END.
- BYZERO: result_o←0, ready_o←1, go to END.
- END:
  - ready_o and result_o are held while start_i=1.
  - When start_i=0: ready_o←0, result_o←0, go to IDLE.
  - No new request is accepted in END, so there is a mandatory idle cycle between divisions.
- annul_i=1 in ON, BYZERO or END: go to IDLE next cycle; ready_o←0; result_o←0; no result is delivered.
- annul_i=1 in IDLE: the request is suppressed.
- Latency, with accept at cycle T:
  - Normal divide: iterations run T+1..T+DATA_W; ready_o is high from T+DATA_W+1 (T+33 at defaults).
  - Divide by zero: ready_o is high at T+2.
- Sign rules (signed mode):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Operand changes on dividend_i/divisor_i after the accept cycle are ignored.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: signed_i is honoured; the magnitude and fix-up logic above is built.
- Undefined: signed_i is ignored, all divisions are unsigned, and no negation logic is generated; latency is unchanged.

Decomposition:
- Shared constants header: DivFree/DivByZero/DivOn/DivEnd state encodings, DivStart/DivStop, DivResultReady/NotReady, DoubleRegBus width define, ZeroWord.
- One natural sub-module: div_step, a combinational single-iteration subtract/compare/shift over the 65-bit working register, instantiated once.

Test Plan:
- Unsigned 100 / 7, start at T → ready_o rises at T+33 with result_o = {0x00000002, 0x0000000E}; stallreq_o is high from T to T+32.
- DIV_SIGNED_EN defined, signed -7 / 2 (0xFFFFFFF9 / 0x2) → result_o = {0xFFFFFFFF, 0xFFFFFFFD}; 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- Divisor 0, start at T → ready_o=1 at T+2 with result_o=0; after start_i drops, state returns to IDLE one cycle later.
- annul_i pulsed at T+10 of a division → ready_o never rises and the block is in IDLE at T+11; a new 0xFFFFFFFF / 0x10 → {0xF, 0x0FFFFFFF}.
- Hold start_i high 3 cycles past ready → ready_o and result_o stay stable; deassert → ready_o=0 and result_o=0 next cycle; restart accepted one cycle later.
- rst asserted mid-ON → all outputs 0 the next cycle; no stale result appears afterwards.
